// File: rtl/fifo_pkg.sv
// fifo_pkg: shared word type, default width and burst-index width helper for the FIFO slice.
package fifo_pkg;
    localparam int WIDTH = 8;
    typedef logic [WIDTH-1:0] word_t;
    // Index width for a counter over n values, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/fifo_skid_buf.sv
// fifo_skid_buf: 2-entry head/tail output buffer with occupancy count.
// Ports: clk, rst_n (async low); push/push_data write the tail; pop retires the head;
// head is the oldest word; occ is 0..2.
module fifo_skid_buf #(
    parameter int WIDTH = fifo_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       occ
);
    logic [WIDTH-1:0] tail;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            occ  <= 2'd0;
        end else begin
            occ <= occ + {1'b0, push} - {1'b0, pop};
            // Head advances from the tail when full, otherwise a push lands directly in an empty or retiring head.
            if (occ == 2'd2 && pop)
                head <= tail;
            else if (push && (occ == 2'd0 || pop))
                head <= push_data;
            if (push && (occ == 2'd2 || (occ == 2'd1 && !pop)))
                tail <= push_data;
        end
    end
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains the FIFO read port into a valid/ready stream framed in bursts.
// Ports: clk, rst_n (async low); empty/data_out/r_en = FIFO read port;
// m_valid/m_ready/m_data/m_last = stream; beat_count = accepted beats since reset (wraps).
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int WIDTH     = fifo_pkg::WIDTH,
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             empty,
    input  logic [WIDTH-1:0] data_out,
    output logic             r_en,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic [CNT_W-1:0] beat_count
);
    localparam int BW = idx_w(BURST_LEN);
    localparam logic [BW-1:0] LAST = BW'(BURST_LEN - 1);

    logic [1:0]    occ;
    logic [2:0]    lvl;
    logic          inflight;
    logic          pop;
    logic [BW-1:0] burst_idx;

    assign m_valid = occ != 2'd0;
    assign pop     = m_valid && m_ready;
    // Slots committed after this cycle; a read is only issued if its returning word is sure to fit.
    assign lvl     = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    assign r_en    = rst_n && !empty && lvl < 3'd2;
    assign m_last  = m_valid && burst_idx == LAST;

    fifo_skid_buf #(.WIDTH(WIDTH)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data (data_out),
        .pop       (pop),
        .head      (m_data),
        .occ       (occ)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight   <= 1'b0;
            burst_idx  <= '0;
            beat_count <= '0;
        end else begin
            inflight <= r_en;
            if (pop) begin
                burst_idx  <= (burst_idx == LAST) ? '0 : burst_idx + 1'b1;
                beat_count <= beat_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: FIFO model plus scoreboard bench for fifo_stream_reader.
module tb_fifo_stream_reader;
    localparam int BL = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          empty = 1'b1;
    logic [7:0]    data_out = '0;
    logic          r_en;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [7:0]    m_data;
    logic          m_last;
    logic [CW-1:0] beat_count;

    fifo_stream_reader #(.WIDTH(8), .BURST_LEN(BL), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .empty      (empty),
        .data_out   (data_out),
        .r_en       (r_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .beat_count (beat_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    int bidx = 0;
    int n_acc = 0;
    int pops = 0;
    int n_last = 0;
    int rd_pulses = 0;
    int cyc = 0;
    int first_cyc = -1;
    int last_cyc = 0;
    logic hv = 1'b0;
    logic [8:0] hd = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Registered-read FIFO: data_out valid the cycle after r_en, empty reflects the current state.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q.delete();
            empty    <= 1'b1;
            data_out <= '0;
        end else begin
            if (r_en) begin
                if (fifo_q.size() == 0) check("underflow", 1, 0);
                else data_out <= fifo_q.pop_front();
            end
            empty <= fifo_q.size() == 0;
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) hv = 1'b0;
        else begin
            if (hv) check("hold", {m_data, m_last}, hd);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) check("spurious", 1, 0);
                else check("data", m_data, exp_q.pop_front());
                check("last", m_last, bidx == BL - 1);
                check("count", beat_count, n_acc);
                if (m_last) n_last++;
                bidx  = (bidx + 1) % BL;
                n_acc = (n_acc + 1) % (1 << CW);
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                pops++;
            end
            if (r_en) rd_pulses++;
            hv = m_valid && !m_ready;
            hd = {m_data, m_last};
        end
    end

    task automatic clear_models();
        exp_q.delete();
        bidx = 0; n_acc = 0; pops = 0; n_last = 0; rd_pulses = 0; first_cyc = -1;
    endtask

    task automatic do_reset();
        @(posedge clk); #3 rst_n = 1'b0;
        #1 clear_models();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic push_words(input int n, input logic [7:0] base, input logic [7:0] step);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(8'(base + step * i));
            exp_q.push_back(8'(base + step * i));
        end
    endtask

    task automatic wait_pops(input int n, input bit toggle);
        int b = 0;
        while (pops < n && b < 200) begin
            @(posedge clk); #1;
            if (toggle) m_ready = ~m_ready;
            b++;
        end
        if (pops < n) check("timeout", pops, n);
    endtask

    initial begin
        // Reset and idle with the FIFO empty.
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("idle_r_en", r_en, 0);
        end
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_last", m_last, 0);
        check("rst_count", beat_count, 0);

        // Streaming four words.
        m_ready = 1'b1;
        push_words(4, 8'h11, 8'h11);
        wait_pops(4, 0);
        @(posedge clk); #1;
        check("stream_count", beat_count, 4);
        check("stream_gap", last_cyc - first_cyc, 3);
        check("stream_lasts", n_last, 1);

        // Backpressure with eight queued words.
        do_reset();
        m_ready = 1'b0;
        push_words(8, 8'hA0, 8'h01);
        repeat (12) @(posedge clk);
        #1;
        check("bp_pulses", rd_pulses, 2);
        check("bp_valid", m_valid, 1);
        check("bp_r_en", r_en, 0);
        m_ready = 1'b1;
        wait_pops(8, 0);
        check("bp_gap", last_cyc - first_cyc, 7);
        check("bp_left", exp_q.size(), 0);

        // Alternating ready over sixteen words.
        do_reset();
        m_ready = 1'b1;
        push_words(16, 8'h30, 8'h03);
        wait_pops(16, 1);
        m_ready = 1'b0;
        @(posedge clk); #1;
        check("alt_lasts", n_last, 4);
        check("alt_count", beat_count, 16 % (1 << CW));
        check("alt_left", exp_q.size(), 0);

        // Reset mid-burst with the buffer full, asserted mid-cycle.
        do_reset();
        m_ready = 1'b1;
        push_words(8, 8'h50, 8'h01);
        wait_pops(2, 0);
        m_ready = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_valid", m_valid, 0);
        check("async_data", m_data, 0);
        check("async_last", m_last, 0);
        check("async_count", beat_count, 0);
        check("async_r_en", r_en, 0);
        clear_models();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_valid", m_valid, 0);
        m_ready = 1'b1;
        push_words(4, 8'hC1, 8'h01);
        wait_pops(1, 0);
        check("restart_count", beat_count, 1);
        wait_pops(4, 0);
        @(posedge clk); #1;
        check("restart_lasts", n_last, 1);

        // Counter wrap with a 4-bit beat counter.
        do_reset();
        m_ready = 1'b1;
        push_words(17, 8'h01, 8'h01);
        wait_pops(17, 0);
        @(posedge clk); #1;
        check("wrap_count", beat_count, 1);
        check("wrap_lasts", n_last, 4);
        check("wrap_last_now", m_last, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
